// File: rtl/pmips_pkg.sv
// Shared definitions for the pmips fetch slice: default widths, the reset PC,
// and the prefetch queue entry layout for the default configuration.
package pmips_pkg;

    localparam int XLEN_DEFAULT     = 16;
    localparam int ILEN_DEFAULT     = 16;
    localparam int RESET_PC_DEFAULT = 0;

    // One queued instruction together with the address of the instruction after it.
    typedef struct packed {
        logic [ILEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pcplus;
    } fetch_entry_t;

endpackage

// File: rtl/pmips_fetch_if.sv
// Instruction-memory and consumer handshake bundle of the pmips fetch unit.
// The master view belongs to the fetch unit; the slave view belongs to the
// memory/consumer environment around it.
interface pmips_fetch_if #(
    parameter int XLEN = pmips_pkg::XLEN_DEFAULT,
    parameter int ILEN = pmips_pkg::ILEN_DEFAULT
);
    logic [XLEN-1:0] imemaddr;
    logic            imemreq;
    logic [ILEN-1:0] imemrdata;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pcplus;
    logic            instr_ready;

    modport master (
        output imemaddr, imemreq, instr_valid, instr, instr_pcplus,
        input  imemrdata, instr_ready
    );

    modport slave (
        input  imemaddr, imemreq, instr_valid, instr, instr_pcplus,
        output imemrdata, instr_ready
    );
endinterface

// File: rtl/pmips_fetch_fifo.sv
// Prefetch queue for the fetch unit: DEPTH entries (power of two), FIFO order,
// synchronous flush that beats push and pop. Pops while empty are ignored;
// the caller guarantees that it never pushes into a full queue.
module pmips_fetch_fifo
    import pmips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;
    logic            do_push;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push;

    // Next pointer/count values; flush empties the queue regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pmips_fetch.sv
// pmips fetch unit: PC register, fetch issue control and a prefetch queue.
// Requests go out one per cycle while queue space (counting the response in
// flight) allows; each response is queued with its address + ILEN/8.
// Optional feature: define PMIPS_FETCH_PERF_EN to add the perf_fetched and
// perf_flushed counters.
module pmips_fetch
    import pmips_pkg::*;
#(
    parameter int          XLEN     = XLEN_DEFAULT,
    parameter int          ILEN     = ILEN_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    pmips_fetch_if.master    bus,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [CW-1:0]    occupancy
`ifdef PMIPS_FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushed
`endif
);
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pcplus;
    } entry_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   fifo_count;
    entry_t          fifo_head;
    entry_t          push_entry;
    logic            head_valid;
    logic            pop;
    logic            push;
    logic            issue;

    assign head_valid = (fifo_count != '0);
    assign pop        = head_valid && bus.instr_ready;
    assign push       = inflight_q && !redirect;

    // The PC already points past the inflight request, so it is that request's pcplus.
    assign push_entry.instr  = bus.imemrdata;
    assign push_entry.pcplus = pc_q;

    // Issue decision and next PC; a redirect suppresses issue and reloads the PC.
    always_comb begin
        issue = !reset && !redirect &&
                ((int'(fifo_count) + int'(inflight_q) - int'(pop)) < DEPTH);
        pc_d  = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + STEP;
        end
        inflight_d = issue;
    end

    // PC and inflight-request registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= XLEN'(RESET_PC);
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    pmips_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imemaddr     = pc_q;
    assign bus.imemreq      = issue;
    assign bus.instr_valid  = head_valid;
    assign bus.instr        = head_valid ? fifo_head.instr  : '0;
    assign bus.instr_pcplus = head_valid ? fifo_head.pcplus : '0;
    assign occupancy        = fifo_count;

`ifdef PMIPS_FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    // Count queued responses, and entries plus inflight responses thrown away by redirects.
    always_comb begin
        fetched_d = fetched_q + 32'(push);
        flushed_d = flushed_q;
        if (redirect) begin
            flushed_d = flushed_q + 32'(fifo_count) + 32'(inflight_q);
        end
    end

    // Performance counter registers; they wrap at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_pmips_fetch.sv
// Directed bench for pmips_fetch with the default parameters. Memory returns
// addr + 0x1000 one cycle after each request, so queued instructions are
// recognisable by their address.
module tb_pmips_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [2:0]  occupancy;
`ifdef PMIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    pmips_fetch_if #(.XLEN(16), .ILEN(16)) bus ();

    pmips_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .occupancy   (occupancy)
`ifdef PMIPS_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Instruction memory: answers in the cycle after a request, junk otherwise.
    always @(posedge clock) begin
        bus.imemrdata <= bus.imemreq ? (bus.imemaddr + 16'h1000) : 16'hDEAD;
    end

    // One cycle: drive inputs at the falling edge, then settle before checking.
    task automatic applyStimulus(input logic rst, input logic rdy,
                                 input logic redir, input logic [15:0] rpc);
        @(negedge clock);
        reset           = rst;
        bus.instr_ready = rdy;
        redirect        = redir;
        redirect_pc     = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        bus.instr_ready = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_req",    32'(bus.imemreq),      32'h0);
        checkOutput("rst_addr",   32'(bus.imemaddr),     32'h0);
        checkOutput("rst_occ",    32'(occupancy),        32'h0);
        checkOutput("rst_valid",  32'(bus.instr_valid),  32'h0);
        checkOutput("rst_instr",  32'(bus.instr),        32'h0);
        checkOutput("rst_pcplus", 32'(bus.instr_pcplus), 32'h0);

        // Streaming with instr_ready high: 2-cycle latency, then one per cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("s_c0_req",   32'(bus.imemreq),     32'h1);
        checkOutput("s_c0_addr",  32'(bus.imemaddr),    32'h0);
        checkOutput("s_c0_valid", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("s_c1_addr",  32'(bus.imemaddr),    32'h2);
        checkOutput("s_c1_valid", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("s_c2_valid",  32'(bus.instr_valid),  32'h1);
        checkOutput("s_c2_instr",  32'(bus.instr),        32'h1000);
        checkOutput("s_c2_pcplus", 32'(bus.instr_pcplus), 32'h2);
        checkOutput("s_c2_addr",   32'(bus.imemaddr),     32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("s_c3_instr",  32'(bus.instr),        32'h1002);
        checkOutput("s_c3_pcplus", 32'(bus.instr_pcplus), 32'h4);
        checkOutput("s_c3_addr",   32'(bus.imemaddr),     32'h6);
        checkOutput("s_c3_occ",    32'(occupancy),        32'h1);

        // Redirect coincident with push and pop: redirect wins
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200);
        checkOutput("rp_req_low", 32'(bus.imemreq), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("rp_occ",   32'(occupancy),       32'h0);
        checkOutput("rp_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rp_addr",  32'(bus.imemaddr),    32'h0200);
        checkOutput("rp_req",   32'(bus.imemreq),     32'h1);

        // Back-to-back redirects: the last target is fetched, nothing stale queued
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0300);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0400);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("rr_addr", 32'(bus.imemaddr), 32'h0400);
        checkOutput("rr_occ",  32'(occupancy),    32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("rr_valid0", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("rr_instr",  32'(bus.instr),        32'h1400);
        checkOutput("rr_pcplus", 32'(bus.instr_pcplus), 32'h0402);

        // Backpressure: queue saturates at 4, then drains in order
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        end
        checkOutput("bp_occ",   32'(occupancy),    32'h4);
        checkOutput("bp_req",   32'(bus.imemreq),  32'h0);
        checkOutput("bp_addr",  32'(bus.imemaddr), 32'h8);
        checkOutput("bp_head",  32'(bus.instr),    32'h1000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput("bp_drain_instr",  32'(bus.instr),        32'h1000 + 32'(2 * i));
            checkOutput("bp_drain_pcplus", 32'(bus.instr_pcplus), 32'(2 * i + 2));
        end

        // Redirect with 3 queued entries and one response in flight
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100);
        checkOutput("fl_occ_before", 32'(occupancy),   32'h3);
        checkOutput("fl_req_low",    32'(bus.imemreq), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("fl_occ",   32'(occupancy),       32'h0);
        checkOutput("fl_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("fl_instr", 32'(bus.instr),       32'h0);
        checkOutput("fl_req",   32'(bus.imemreq),     32'h1);
        checkOutput("fl_addr",  32'(bus.imemaddr),    32'h0100);
`ifdef PMIPS_FETCH_PERF_EN
        checkOutput("fl_perf_flushed", perf_flushed, 32'h4);
        checkOutput("fl_perf_fetched", perf_fetched, 32'h3);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("fl_addr2",  32'(bus.imemaddr),    32'h0102);
        checkOutput("fl_valid2", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("fl_instr3",  32'(bus.instr),        32'h1100);
        checkOutput("fl_pcplus3", 32'(bus.instr_pcplus), 32'h0102);

        // PC wrap at the top of the 16-bit address space
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
        checkOutput("wr_req_low", 32'(bus.imemreq), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("wr_addr0", 32'(bus.imemaddr), 32'hFFFE);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("wr_addr1", 32'(bus.imemaddr), 32'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("wr_instr",  32'(bus.instr),        32'h0FFE);
        checkOutput("wr_pcplus", 32'(bus.instr_pcplus), 32'h0000);
        checkOutput("wr_addr2",  32'(bus.imemaddr),     32'h0002);

        // Reset pulse mid-stream with two entries queued
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        end
        checkOutput("mr_occ_before", 32'(occupancy), 32'h2);
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_occ",    32'(occupancy),        32'h0);
        checkOutput("mr_valid",  32'(bus.instr_valid),  32'h0);
        checkOutput("mr_instr",  32'(bus.instr),        32'h0);
        checkOutput("mr_pcplus", 32'(bus.instr_pcplus), 32'h0);
        checkOutput("mr_req",    32'(bus.imemreq),      32'h0);
        checkOutput("mr_addr",   32'(bus.imemaddr),     32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("mr_rel_req",  32'(bus.imemreq),  32'h1);
        checkOutput("mr_rel_addr", 32'(bus.imemaddr), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("mr_rel_instr", 32'(bus.instr), 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmips_fetch.md
PMIPS_FETCH -- requirements
Module: pmips_fetch

Interface
REQ-001 Param XLEN, default 16, PC/instruction-address width in bits.
REQ-002 Param ILEN, default 16, instruction width in bits; a multiple of 8.
REQ-003 Param DEPTH, default 4, prefetch queue entries; a power of two, at least 2.
REQ-004 Param RESET_PC, default 0, PC value loaded on reset.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 imemaddr  output  XLEN  instruction memory address (current PC).
REQ-008 imemreq  output  1  fetch request; imemaddr is valid while high.
REQ-009 imemrdata  input  ILEN  instruction data; valid in the cycle after the request.
REQ-010 redirect  input  1  branch taken or flush; PC is reloaded from redirect_pc.
REQ-011 redirect_pc  input  XLEN  redirect target address.
REQ-012 instr_valid  output  1  queue head holds a valid instruction.
REQ-013 instr  output  ILEN  queue head instruction; zero when the queue is empty.
REQ-014 instr_pcplus  output  XLEN  address of the head instruction plus ILEN/8.
REQ-015 instr_ready  input  1  consumer accepts the head when instr_valid and instr_ready are both high.
REQ-016 occupancy  output  $clog2(DEPTH+1)  number of valid queue entries.

Function
REQ-017 Issue: imemreq is high when not redirect and (occupancy + inflight - pop) < DEPTH. Inflight is a 1-bit flag set by the previous cycle's issue.
REQ-018 On issue, the PC advances by ILEN/8 at the clock edge; the sum wraps modulo 2^XLEN.
REQ-019 The response (imemrdata) is pushed in the cycle after issue, paired with its address+ILEN/8. instr_valid rises on the following edge, so issue-to-valid latency is 2 cycles.
REQ-020 Throughput: with instr_ready held high, the block sustains 1 instruction per cycle.
REQ-021 A pop removes the head; a simultaneous push and pop leaves occupancy unchanged; order is FIFO.
REQ-022 Overflow is impossible by construction (REQ-017). A pop while empty is ignored.
REQ-023 Redirect: at the edge, the queue is emptied, any inflight response is discarded (not pushed), and PC <= redirect_pc. imemreq is low during the redirect cycle.
REQ-024 Redirect takes priority over push, pop and issue in the same cycle. Consecutive redirects: the last one wins.
REQ-025 The first request after a redirect is issued in the next cycle at redirect_pc.
REQ-026 Pointers are log2(DEPTH) bits and wrap naturally. Full: occupancy == DEPTH. Empty: occupancy == 0.

Reset
REQ-027 While reset is high: PC = RESET_PC, imemreq = 0, inflight = 0, occupancy = 0, instr_valid = 0, instr = 0, instr_pcplus = 0.
REQ-028 Reset asserted mid-operation discards all queued and inflight instructions immediately.
REQ-029 The first issue is at RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-030 Macro PMIPS_FETCH_PERF_EN defined: adds outputs perf_fetched (32-bit, count of pushes) and perf_flushed (32-bit, count of entries plus inflight responses discarded by redirect). Both reset to 0 and wrap at 2^32.
REQ-031 Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package pmips_pkg holds the XLEN/ILEN defaults, the RESET_PC default, and the queue entry typedef {instr, pcplus}.
REQ-033 The queue is a sub-module, pmips_fetch_fifo (DEPTH-parameterised, with synchronous flush); PC and issue logic stay in pmips_fetch.

Verification
REQ-034 Reset release, instr_ready=1, memory returns addr-based data -> imemaddr sequence 0,2,4,6; first instr_valid in cycle 2 with instr_pcplus=2; one instruction per cycle afterwards.
REQ-035 instr_ready=0 for 10 cycles -> occupancy saturates at 4, imemreq low, no data lost; after release the instructions for addresses 0..6 emerge in order.
REQ-036 Redirect to 0x0100 while occupancy=3 with a request inflight -> occupancy=0 next cycle, then the next issue is at 0x0100; no stale instruction appears; perf_flushed=4 when PMIPS_FETCH_PERF_EN is defined.
REQ-037 PC=0xFFFE, XLEN=16 -> next issue address 0x0000; instr_pcplus for the 0xFFFE instruction = 0x0000.
REQ-038 Reset pulse mid-stream at occupancy=2 -> outputs zero immediately; the first issue after release is at RESET_PC.
REQ-039 Redirect coincident with pop and push -> redirect dominates; occupancy=0 and PC=redirect_pc.
